// File: rtl/logos_pkg.sv
// Shared definitions for the logos NTT command dispatcher: opcodes, command
// field positions and the issue-decision encoding.
package logos_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_EXEC = 8'h01;
  localparam logic [7:0] OP_SYNC = 8'h02;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam int OP_LSB   = 56;
  localparam int TGT_LSB  = 52;
  localparam int MASK_LSB = 40;

  localparam logic [3:0] ANY_CORE = 4'hF;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_POP,
    ACT_ISSUE,
    ACT_BAD,
    ACT_HALT
  } action_e;

endpackage

// File: rtl/logos_cmd_fifo.sv
// Command FIFO with a combinational head; a push into a full FIFO is accepted
// when the head is popped in the same cycle. Flush empties it.
module logos_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/logos_dispatch.sv
// N-core NTT command dispatcher: in-order issue from a command FIFO with
// per-core busy/bank-mask hazard tracking, SYNC/HALT handling and perf counters.
module logos_dispatch
  import logos_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int NUM_BANKS  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  input  logic [63:0]                cmd_data,
  output logic                       cmd_ready,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [63:0]                core_cmd,
  input  logic [NUM_CORES-1:0]       core_done,
  output logic                       halted,
  output logic                       idle,
  output logic                       err_bad_target,
  output logic [NUM_CORES*CNT_W-1:0] perf_ops,
  output logic [CNT_W-1:0]           perf_stall
);

  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [63:0]          head;
  logic [7:0]           head_op;
  logic [3:0]           head_tgt;
  logic [NUM_BANKS-1:0] head_mask;

  logic [NUM_CORES-1:0] busy_q, busy_d, start_q, start_d;
  logic [NUM_BANKS-1:0] mask_q [NUM_CORES];
  logic [NUM_BANKS-1:0] mask_d [NUM_CORES];
  logic [CNT_W-1:0]     ops_q  [NUM_CORES];
  logic [CNT_W-1:0]     ops_d  [NUM_CORES];
  logic [CNT_W-1:0]     stall_q, stall_d;
  logic [63:0]          cmd_q, cmd_d;
  logic                 halt_seen_q, halt_seen_d;
  logic                 halted_q, halted_d;
  logic                 err_q, err_d;

  logic [NUM_BANKS-1:0] busy_banks;
  logic [NUM_CORES-1:0] tgt_oh, idle_oh, cand;
  logic                 idle_found;
  action_e              act;

  assign fifo_push = cmd_valid && cmd_ready;
  assign head_op   = head[OP_LSB +: 8];
  assign head_tgt  = head[TGT_LSB +: 4];
  assign head_mask = head[MASK_LSB +: NUM_BANKS];

  logos_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (cmd_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue decision on the FIFO head against the registered busy/mask table.
  always_comb begin
    busy_banks = '0;
    idle_oh    = '0;
    tgt_oh     = '0;
    idle_found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (busy_q[i]) busy_banks = busy_banks | mask_q[i];
      if (!busy_q[i] && !idle_found) begin
        idle_oh[i] = 1'b1;
        idle_found = 1'b1;
      end
      if (head_tgt == 4'(i)) tgt_oh[i] = 1'b1;
    end
    cand = (head_tgt == ANY_CORE) ? idle_oh : tgt_oh;

    act = ACT_HOLD;
    if (!fifo_empty) begin
      case (head_op)
        OP_EXEC: begin
          if (head_tgt != ANY_CORE && tgt_oh == '0) act = ACT_BAD;
          else if ((cand & ~busy_q) != '0 && (head_mask & busy_banks) == '0)
            act = ACT_ISSUE;
        end
        OP_SYNC: if (busy_q == '0) act = ACT_POP;
        OP_HALT: if (busy_q == '0) act = ACT_HALT;
        OP_NOP:  act = ACT_POP;
        default: act = ACT_POP;
      endcase
    end
  end

  always_comb begin
    fifo_pop    = (act != ACT_HOLD);
    fifo_flush  = (act == ACT_HALT);
    start_d     = (act == ACT_ISSUE) ? cand : '0;
    cmd_d       = (act == ACT_ISSUE) ? head : cmd_q;
    stall_d     = (!fifo_empty && act == ACT_HOLD) ? stall_q + CNT_W'(1) : stall_q;
    halt_seen_d = halt_seen_q || (fifo_push && cmd_data[OP_LSB +: 8] == OP_HALT);
    halted_d    = halted_q || (act == ACT_HALT);
    err_d       = err_q || (act == ACT_BAD);
    busy_d      = busy_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      mask_d[i] = mask_q[i];
      ops_d[i]  = ops_q[i];
      if (start_d[i]) begin
        busy_d[i] = 1'b1;
        mask_d[i] = head_mask;
        ops_d[i]  = ops_q[i] + CNT_W'(1);
      end else if (core_done[i]) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      start_q     <= '0;
      cmd_q       <= '0;
      stall_q     <= '0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        mask_q[i] <= '0;
        ops_q[i]  <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      start_q     <= start_d;
      cmd_q       <= cmd_d;
      stall_q     <= stall_d;
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        mask_q[i] <= mask_d[i];
        ops_q[i]  <= ops_d[i];
      end
    end
  end

  assign cmd_ready      = !fifo_full && !halt_seen_q;
  assign core_start     = start_q;
  assign core_cmd       = cmd_q;
  assign halted         = halted_q;
  assign idle           = fifo_empty && (busy_q == '0);
  assign err_bad_target = err_q;
  assign perf_stall     = stall_q;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_perf
    assign perf_ops[gi*CNT_W +: CNT_W] = ops_q[gi];
  end

endmodule
